// File: rtl/triangle_host.sv
// Host-side driver/collector for the triangle rasterizer: sends three vertices,
// then gathers the returned point stream into a count/checksum/timeout summary.
module triangle_host #(
    parameter int BUSY_TMO = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [17:0] req_tri,
    output logic        nt,
    output logic [2:0]  xi,
    output logic [2:0]  yi,
    input  logic        busy,
    input  logic        po,
    input  logic [2:0]  xo,
    input  logic [2:0]  yo,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [5:0]  res_count,
    output logic [11:0] res_sum,
    output logic        res_timeout
);

    // state   | meaning
    // IDLE    | waiting for a request while the rasterizer is idle
    // SEND0-2 | presenting vertex 0..2 on xi/yi (nt with vertex 0)
    // WAIT    | waiting for busy to rise, bounded by BUSY_TMO
    // COLLECT | accumulating points until busy falls
    // REPORT  | summary held on res_* until accepted
    typedef enum logic [2:0] {
        IDLE, SEND0, SEND1, SEND2, WAIT, COLLECT, REPORT
    } state_t;

    localparam logic [3:0] TMO_LAST = 4'(BUSY_TMO - 1);

    state_t      state, state_nxt;
    logic [17:0] tri_q;
    logic [3:0]  wait_cnt;
    logic        accept;
    logic        tmo_hit;
    logic        count_en;

    assign req_ready = (state == IDLE) && !busy;
    assign accept    = req_valid && req_ready;
    assign res_valid = (state == REPORT);
    assign count_en  = po && ((state == WAIT) || (state == COLLECT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = SEND0;
            SEND0:   state_nxt = SEND1;
            SEND1:   state_nxt = SEND2;
            SEND2:   state_nxt = WAIT;
            WAIT: begin
                if (busy) begin
                    state_nxt = COLLECT;
                end else if (wait_cnt == TMO_LAST) begin
                    state_nxt = REPORT;
                    tmo_hit   = 1'b1;
                end
            end
            COLLECT: if (!busy) state_nxt = REPORT;
            REPORT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vertex outputs are loaded from the next state so they line up with SENDk;
    // vertex 0 comes straight from req_tri because tri_q loads on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nt <= 1'b0;
            xi <= 3'd0;
            yi <= 3'd0;
        end else begin
            nt <= (state_nxt == SEND0);
            case (state_nxt)
                SEND0:   {yi, xi} <= req_tri[5:0];
                SEND1:   {yi, xi} <= tri_q[11:6];
                SEND2:   {yi, xi} <= tri_q[17:12];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tri_q       <= 18'd0;
            wait_cnt    <= 4'd0;
            res_count   <= 6'd0;
            res_sum     <= 12'd0;
            res_timeout <= 1'b0;
        end else if (accept) begin
            tri_q       <= req_tri;
            wait_cnt    <= 4'd0;
            res_count   <= 6'd0;
            res_sum     <= 12'd0;
            res_timeout <= 1'b0;
        end else begin
            if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
            if (tmo_hit) res_timeout <= 1'b1;
            if (count_en) begin
                if (res_count != 6'd63) res_count <= res_count + 6'd1;
                res_sum <= res_sum + {6'd0, yo, xo};
            end
        end
    end

endmodule

// File: tb/tb_triangle_host.sv
// Randomized bench for triangle_host: a driver plays host and rasterizer, a monitor
// checks vertex sequences and summaries against expectations queued at issue time.
module tb_triangle_host;
    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [17:0] req_tri;
    logic        nt;
    logic [2:0]  xi;
    logic [2:0]  yi;
    logic        busy;
    logic        po;
    logic [2:0]  xo;
    logic [2:0]  yo;
    logic        res_valid;
    logic        res_ready;
    logic [5:0]  res_count;
    logic [11:0] res_sum;
    logic        res_timeout;

    triangle_host #(.BUSY_TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_tri(req_tri),
        .nt(nt), .xi(xi), .yi(yi),
        .busy(busy), .po(po), .xo(xo), .yo(yo),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_sum(res_sum), .res_timeout(res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    logic [17:0] vq[$];
    logic [18:0] rq[$];

    // Rasterizer plan, indexed by cycle i after the SEND2 cycle (i = 1..n)
    bit       pl_po[0:127];
    logic [2:0] pl_x[0:127];
    logic [2:0] pl_y[0:127];

    task automatic clr_plan();
        for (int i = 0; i < 128; i++) begin
            pl_po[i] = 1'b0; pl_x[i] = 3'd0; pl_y[i] = 3'd0;
        end
    endtask

    task automatic rnd_plan(input int n);
        for (int i = 1; i <= n; i++) begin
            pl_po[i] = 1'($urandom % 2);
            pl_x[i]  = 3'($urandom);
            pl_y[i]  = 3'($urandom);
        end
    endtask

    task automatic set_pt(input int i, input int x, input int y);
        pl_po[i] = 1'b1; pl_x[i] = 3'(x); pl_y[i] = 3'(y);
    endtask

    task automatic run_tri(input logic [17:0] t, input bit tmo, input int d, input int nb,
                           input int bp, input bit gate, input bit rst_mid);
        int ncyc;
        int tot;
        int sum;
        int w;
        ncyc = tmo ? TMO : d + nb;
        tot = 0;
        sum = 0;
        for (int i = 1; i <= ncyc; i++)
            if (pl_po[i]) begin
                tot++;
                sum += pl_y[i] * 8 + pl_x[i];
            end
        vq.push_back(t);
        if (!rst_mid) rq.push_back({tmo, 6'((tot > 63) ? 63 : tot), 12'(sum % 4096)});

        if (gate) begin
            @(posedge clk); #1;
            busy = 1'b1; req_valid = 1'b1; req_tri = t;
            repeat (3) begin
                @(negedge clk);
                chk("gate_req_ready", 32'(req_ready), 0);
                chk("gate_nt", 32'(nt), 0);
            end
            @(posedge clk); #1;
            busy = 1'b0;
            @(negedge clk);
            chk("ungate_req_ready", 32'(req_ready), 1);
        end else begin
            w = 0;
            @(negedge clk);
            while (!req_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("req_ready_wait", 32'(req_ready), 1);
            req_valid = 1'b1; req_tri = t;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_tri = 18'($urandom);
        @(negedge clk);
        chk("nt_after_accept", 32'(nt), 1);
        @(posedge clk); #1;
        if (rst_mid) begin
            reset = 1'b0;
            #1;
            chk("rst_nt", 32'(nt), 0);
            chk("rst_xi", 32'(xi), 0);
            chk("rst_yi", 32'(yi), 0);
            chk("rst_res_valid", 32'(res_valid), 0);
            @(posedge clk); #1;
            reset = 1'b1;
            return;
        end
        @(posedge clk); #1;
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk); #1;
            busy = !tmo && (i >= d) && (i < d + nb);
            po = pl_po[i]; xo = pl_x[i]; yo = pl_y[i];
        end
        @(negedge clk);
        chk("res_valid_before_report", 32'(res_valid), 0);
        @(posedge clk); #1;
        busy = 1'b0; po = 1'b0; res_ready = (bp == 0);
        @(negedge clk);
        chk("res_valid_latency", 32'(res_valid), 1);
        for (int j = 1; j <= bp; j++) begin
            @(posedge clk); #1;
            res_ready = (j == bp);
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    // Monitor
    int          phase = 0;
    logic [17:0] cur_tri;
    bit          have_prev = 0;
    bit          after_hs = 0;
    logic [18:0] prev_res;
    logic [18:0] exp_res;

    always @(negedge clk) begin
        if (!reset) begin
            phase = 0; have_prev = 0; after_hs = 0;
        end else begin
            if (phase == 1 || phase == 2) begin
                chk("vtx_nt_low", 32'(nt), 0);
                chk("vtx_xi", 32'(xi), 32'(phase == 1 ? cur_tri[8:6] : cur_tri[14:12]));
                chk("vtx_yi", 32'(yi), 32'(phase == 1 ? cur_tri[11:9] : cur_tri[17:15]));
                phase = (phase == 2) ? 0 : phase + 1;
            end else if (nt) begin
                if (vq.size() == 0) begin
                    chk("nt_unexpected", 1, 0);
                end else begin
                    cur_tri = vq.pop_front();
                    chk("vtx0_xi", 32'(xi), 32'(cur_tri[2:0]));
                    chk("vtx0_yi", 32'(yi), 32'(cur_tri[5:3]));
                    phase = 1;
                end
            end

            if (after_hs) begin
                chk("res_valid_drop", 32'(res_valid), 0);
                chk("req_ready_after_hs", 32'(req_ready), 32'(!busy));
                after_hs = 0;
            end
            if (res_valid) begin
                chk("req_ready_in_report", 32'(req_ready), 0);
                if (have_prev)
                    chk("res_stable", 32'({res_timeout, res_count, res_sum}), 32'(prev_res));
                prev_res = {res_timeout, res_count, res_sum};
                have_prev = 1;
                if (res_ready) begin
                    have_prev = 0;
                    after_hs = 1;
                    if (rq.size() == 0) begin
                        chk("res_unexpected", 1, 0);
                    end else begin
                        exp_res = rq.pop_front();
                        chk("res_timeout", 32'(res_timeout), 32'(exp_res[18]));
                        chk("res_count", 32'(res_count), 32'(exp_res[17:12]));
                        chk("res_sum", 32'(res_sum), 32'(exp_res[11:0]));
                    end
                end
            end else begin
                have_prev = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit tmo;
        int d;
        int nb;
        reset = 1'b0; req_valid = 1'b0; req_tri = 18'd0; busy = 1'b0;
        po = 1'b0; xo = 3'd0; yo = 3'd0; res_ready = 1'b0;
        #12;
        chk("reset_nt", 32'(nt), 0);
        chk("reset_xi", 32'(xi), 0);
        chk("reset_yi", 32'(yi), 0);
        chk("reset_res_valid", 32'(res_valid), 0);
        chk("reset_res_count", 32'(res_count), 0);
        chk("reset_res_sum", 32'(res_sum), 0);
        chk("reset_res_timeout", 32'(res_timeout), 0);
        chk("reset_req_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        reset = 1'b1;

        // Normal triangle, with busy gating ahead of acceptance
        clr_plan();
        set_pt(2, 1, 1); set_pt(3, 2, 1); set_pt(4, 1, 2); set_pt(5, 2, 2); set_pt(6, 1, 3);
        run_tri({3'd3, 3'd1, 3'd1, 3'd3, 3'd1, 3'd1}, 1'b0, 2, 5, 1, 1'b1, 1'b0);

        clr_plan();
        run_tri(18'($urandom), 1'b1, 0, 0, 0, 1'b0, 1'b0);

        clr_plan(); rnd_plan(6);
        run_tri(18'($urandom), 1'b0, 2, 4, 10, 1'b0, 1'b0);

        clr_plan();
        set_pt(1, 3, 2); set_pt(3, 7, 7);
        run_tri(18'($urandom), 1'b0, 1, 2, 0, 1'b0, 1'b0);

        clr_plan();
        for (int i = 1; i <= 71; i++) set_pt(i, 7, 7);
        run_tri(18'($urandom), 1'b0, 1, 70, 2, 1'b0, 1'b0);

        clr_plan();
        run_tri(18'($urandom), 1'b0, 1, 1, 0, 1'b0, 1'b1);

        clr_plan(); rnd_plan(5);
        run_tri(18'($urandom), 1'b0, 1, 4, 0, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            tmo = ($urandom % 5 == 0);
            d = $urandom_range(1, TMO);
            nb = $urandom_range(1, 12);
            clr_plan();
            rnd_plan(tmo ? TMO : d + nb);
            run_tri(18'($urandom), tmo, d, nb, $urandom_range(0, 3), ($urandom % 4 == 0), 1'b0);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("res_queue_drained", 32'(rq.size()), 0);
        chk("vtx_queue_drained", 32'(vq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/triangle_host.md
# triangle_host

Host-side driver and collector for the triangle rasterizer. It takes one triangle per request from an upstream port and sends it over the rasterizer's vertex-load interface (nt, xi, yi). It then collects the point stream (busy, po, xo, yo) that comes back and returns a per-triangle summary: point count, checksum and timeout flag. It sits between the system controller and the rasterizer, one instance per rasterizer.

## Interface
- BUSY_TMO, default 4: number of cycles in WAIT without seeing busy=1 before the triangle is declared timed out; range 1..15.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  upstream triangle valid.
- req_ready  output  1  upstream ready; combinational, equals (state==IDLE && busy==0).
- req_tri  input  18  packed vertices {y2,x2,y1,x1,y0,x0}, 3 bits each.
- nt  output  1  new-triangle strobe to the rasterizer; registered.
- xi, yi  output  3 each  vertex coordinate to the rasterizer; registered.
- busy  input  1  rasterizer busy.
- po  input  1  rasterizer point-valid.
- xo, yo  input  3 each  rasterizer point coordinate.
- res_valid  output  1  summary valid; held until accepted.
- res_ready  input  1  downstream accept.
- res_count  output  6  number of po=1 cycles collected; saturates at 63.
- res_sum  output  12  sum over collected points of {yo,xo}, i.e. yo*8+xo; wraps mod 4096.
- res_timeout  output  1  1 = busy never rose within BUSY_TMO cycles.

## Operation
- States: IDLE, SEND0, SEND1, SEND2, WAIT, COLLECT, REPORT.
- **IDLE**
  - On req_valid && req_ready, latch req_tri, clear count, sum, timeout flag and the wait counter, then go to SEND0.
  - req_valid while busy=1 is not accepted.
- **SEND0 / SEND1 / SEND2**
  - During SENDk, registered outputs present xi=xk, yi=yk.
  - nt=1 only during SEND0.
  - Sequence is SEND0 → SEND1 → SEND2 → WAIT unconditionally.
  - Outside the SEND states: nt=0, and xi, yi hold their last value.
- **WAIT**
  - Counter increments each cycle.
  - busy=1 → COLLECT.
  - Counter reaches BUSY_TMO with busy=0 → REPORT with res_timeout=1.
  - po=1 in WAIT is counted.
- **COLLECT**
  - Each cycle with po=1: count+1 (saturating at 63); sum += {yo,xo}.
  - busy=0 → REPORT. A po=1 in that same final cycle is still counted.
- **REPORT**
  - res_valid=1; res_count, res_sum and res_timeout are stable.
  - On res_ready=1 → IDLE; res_valid drops the next cycle.
  - req_ready=0 throughout REPORT.
- **Reset** (asynchronous, any state): state=IDLE, nt=0, xi=yi=0, res_valid=0, res_count=0, res_sum=0, res_timeout=0, wait counter=0. A triangle in flight is abandoned with no report.

## Timing
- **Accept to send:** request accepted at edge k → nt=1 with v0 in cycle k+1; v1 in k+2; v2 in k+3; WAIT from k+4.
- **Timeout latency:** with busy stuck low, REPORT is entered BUSY_TMO cycles after WAIT entry, and res_valid is seen in the following cycle.
- **Summary latency:** the cycle after busy is sampled 0 in COLLECT, res_valid=1.
- **Summary handshake:** a one-cycle res_ready pulse completes the handshake. Back-to-back: req_ready can be 1 in the cycle after the res handshake edge.
- **Latency floor:** zero-point triangle (busy rises then falls, no po) gives res_count=0, res_sum=0, res_timeout=0. Minimum request-to-report latency is 6 cycles.

## Test plan
- **Normal triangle:** req_tri with v0=(1,1), v1=(3,1), v2=(1,3). Bench model raises busy 2 cycles after v2 and emits po on (1,1),(2,1),(1,2),(2,2),(1,3), then drops busy.
  - nt pulses once with xi/yi = 1/1, 3/1, 1/3 on consecutive cycles.
  - Result: res_count=5, res_sum=79, res_timeout=0.
- **Timeout:** BUSY_TMO=4, busy held 0.
  - REPORT is entered 4 cycles after WAIT entry.
  - Result: res_timeout=1, res_count=0, res_sum=0.
- **Busy gating:** busy=1 in IDLE with req_valid=1 → req_ready=0 and nt stays 0. busy falls → request accepted next edge.
- **Result backpressure:** res_ready=0 for 10 cycles → res_valid and all result fields stable and req_ready=0 throughout; res_ready=1 → IDLE next cycle.
- **Final-cycle point:** po=1 with (7,7) on the same cycle busy falls → counted; res_sum includes 63.
- **Reset mid-send:** reset asserted during SEND1 → nt=0 and xi=yi=0 immediately, no res_valid. After release, a new request proceeds normally.
